// File: rtl/dec_scan_n_if.sv
// Bus bundle for dec_scan_n: control/select inputs and registered decode outputs.
interface dec_scan_n_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  localparam int NOUT = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [NOUT-1:0]    y;
  logic [SEL_W-1:0]   cur_idx;
  logic               wrap;

  modport master (output en, mode, sel, dwell, input y, cur_idx, wrap);
  modport slave  (input en, mode, sel, dwell, output y, cur_idx, wrap);
endinterface

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N decoder with selectable polarity, enable, and an
// auto-scan mode that walks the outputs with a programmable dwell.
module dec_scan_n #(
  parameter int SEL_W      = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int DWELL_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  dec_scan_n_if.slave bus
);
  localparam int NOUT = 1 << SEL_W;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [NOUT-1:0] INACT = {NOUT{POL}};
  localparam logic [NOUT-1:0] ON0   = INACT ^ NOUT'(1);

  typedef enum logic [1:0] {S_OFF, S_DIRECT, S_SCAN} state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_inc;
  logic [DWELL_W-1:0] cnt_q;
  logic [NOUT-1:0]    y_q;
  logic [NOUT-1:0]    dec_sel;
  logic [NOUT-1:0]    dec_inc;
  logic               wrap_q;

  // SEL_W-bit add wraps NOUT-1 -> 0 for free.
  assign idx_inc = idx_q + 1'b1;

  for (genvar g = 0; g < NOUT; g++) begin : g_dec
    assign dec_sel[g] = (bus.sel == SEL_W'(g)) ^ POL;
    assign dec_inc[g] = (idx_inc == SEL_W'(g)) ^ POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      y_q     <= INACT;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!bus.en) begin
        state_q <= S_OFF;
        y_q     <= INACT;
        cnt_q   <= '0;
      end else if (!bus.mode) begin
        state_q <= S_DIRECT;
        y_q     <= dec_sel;
        idx_q   <= bus.sel;
        cnt_q   <= '0;
      end else if (state_q != S_SCAN) begin
        state_q <= S_SCAN;
        y_q     <= ON0;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else if (cnt_q >= bus.dwell) begin
        // >= rather than == so a live dwell drop below cnt advances at once
        cnt_q  <= '0;
        idx_q  <= idx_inc;
        y_q    <= dec_inc;
        wrap_q <= &idx_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.cur_idx = idx_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: directed scenarios plus randomized run against a model,
// on a 4-output active-low build and an 8-output active-high build.
module tb_dec_scan_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dec_scan_n_if #(.SEL_W(2), .DWELL_W(4)) b0 ();
  dec_scan_n_if #(.SEL_W(3), .DWELL_W(4)) b1 ();

  dec_scan_n #(.SEL_W(2), .ACTIVE_LOW(1), .DWELL_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  dec_scan_n #(.SEL_W(3), .ACTIVE_LOW(0), .DWELL_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Reference: an output is lit or not, at position pos, having been held 'held' extra cycles.
  bit mon[2], mscan[2], mwrap[2];
  int mpos[2], mheld[2];

  function automatic void mstep(int k, bit e, bit m, int s, int d, int nout);
    mwrap[k] = 1'b0;
    if (rst) begin
      mon[k] = 0; mscan[k] = 0; mpos[k] = 0; mheld[k] = 0;
    end else if (!e) begin
      mon[k] = 0; mscan[k] = 0;
    end else if (!m) begin
      mon[k] = 1; mscan[k] = 0; mpos[k] = s;
    end else if (!mscan[k]) begin
      mon[k] = 1; mscan[k] = 1; mpos[k] = 0; mheld[k] = 0;
    end else if (mheld[k] >= d) begin
      mheld[k] = 0;
      mwrap[k] = (mpos[k] == nout - 1);
      mpos[k]  = (mpos[k] + 1) % nout;
    end else begin
      mheld[k]++;
    end
  endfunction

  function automatic logic [7:0] my(int k, int nout, bit al);
    logic [7:0] v;
    logic [7:0] mask;
    mask = 8'((1 << nout) - 1);
    v = mon[k] ? (8'd1 << mpos[k]) : 8'd0;
    if (al) v = ~v;
    return v & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    mstep(0, b0.en, b0.mode, int'(b0.sel), int'(b0.dwell), 4);
    mstep(1, b1.en, b1.mode, int'(b1.sel), int'(b1.dwell), 8);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.en = 0; b0.mode = 0; b0.sel = '0; b0.dwell = '0;
    b1.en = 0; b1.mode = 0; b1.sel = '0; b1.dwell = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_tests++; if (b0.y !== 4'b1111) begin n_fail++; $display("FAIL reset_y0: got %b exp 1111", b0.y); end
    n_tests++; if (b0.cur_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx0: got %0d exp 0", b0.cur_idx); end
    n_tests++; if (b0.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap0: got %b exp 0", b0.wrap); end
    n_tests++; if (b1.y !== 8'h00) begin n_fail++; $display("FAIL reset_y1: got %b exp 00000000", b1.y); end
  endtask

  task automatic test_direct();
    logic [3:0] exp_y [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    b0.en = 1; b0.mode = 0;
    for (int i = 0; i < 4; i++) begin
      b0.sel = 2'(i);
      tick();
      n_tests++; if (b0.y !== exp_y[i]) begin n_fail++; $display("FAIL direct_y sel=%0d: got %b exp %b", i, b0.y, exp_y[i]); end
      n_tests++; if (b0.cur_idx !== 2'(i)) begin n_fail++; $display("FAIL direct_idx sel=%0d: got %0d", i, b0.cur_idx); end
    end
    b0.en = 0;
    tick();
    n_tests++; if (b0.y !== 4'b1111) begin n_fail++; $display("FAIL direct_off_y: got %b exp 1111", b0.y); end
    n_tests++; if (b0.cur_idx !== 2'd3) begin n_fail++; $display("FAIL direct_off_idx_hold: got %0d exp 3", b0.cur_idx); end
  endtask

  task automatic test_scan_dwell0();
    logic [3:0] ey;
    b0.en = 1; b0.mode = 1; b0.dwell = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      ey = ~(4'b0001 << (i % 4));
      n_tests++; if (b0.cur_idx !== 2'(i % 4)) begin n_fail++; $display("FAIL scan0_idx t=%0d: got %0d exp %0d", i, b0.cur_idx, i % 4); end
      n_tests++; if (b0.wrap !== (i == 4 || i == 8)) begin n_fail++; $display("FAIL scan0_wrap t=%0d: got %b", i, b0.wrap); end
      n_tests++; if (b0.y !== ey) begin n_fail++; $display("FAIL scan0_y t=%0d: got %b exp %b", i, b0.y, ey); end
    end
  endtask

  task automatic test_dwell_change();
    int eidx [4] = '{2, 3, 0, 1};
    b0.en = 0;
    tick();
    b0.en = 1; b0.mode = 1; b0.dwell = 4'd2;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_tests++; if (b0.cur_idx !== 2'(t / 3)) begin n_fail++; $display("FAIL dwell2_idx t=%0d: got %0d exp %0d", t, b0.cur_idx, t / 3); end
    end
    b0.dwell = 4'd0;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_tests++; if (b0.cur_idx !== 2'(eidx[t])) begin n_fail++; $display("FAIL dwell_drop_idx t=%0d: got %0d exp %0d", t, b0.cur_idx, eidx[t]); end
      n_tests++; if (b0.wrap !== (t == 2)) begin n_fail++; $display("FAIL dwell_drop_wrap t=%0d: got %b", t, b0.wrap); end
    end
  endtask

  task automatic test_rst_midscan();
    int guard = 0;
    while (b0.cur_idx !== 2'd2 && guard < 8) begin tick(); guard++; end
    n_tests++; if (b0.cur_idx !== 2'd2) begin n_fail++; $display("FAIL midscan_reach_idx2: got %0d exp 2", b0.cur_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (b0.y !== 4'b1111) begin n_fail++; $display("FAIL midscan_rst_y: got %b exp 1111", b0.y); end
    n_tests++; if (b0.cur_idx !== 2'd0) begin n_fail++; $display("FAIL midscan_rst_idx: got %0d exp 0", b0.cur_idx); end
    n_tests++; if (b0.wrap !== 1'b0) begin n_fail++; $display("FAIL midscan_rst_wrap: got %b exp 0", b0.wrap); end
    tick();
    n_tests++; if (b0.y !== 4'b1110 || b0.cur_idx !== 2'd0) begin n_fail++; $display("FAIL midscan_restart: got y=%b idx=%0d exp 1110/0", b0.y, b0.cur_idx); end
    tick();
    n_tests++; if (b0.cur_idx !== 2'd1) begin n_fail++; $display("FAIL midscan_step: got %0d exp 1", b0.cur_idx); end
  endtask

  task automatic test_wide();
    int nwrap = 0;
    int first = -1;
    b0.en = 0;
    b1.en = 1; b1.mode = 0; b1.sel = 3'd5;
    tick();
    n_tests++; if (b1.y !== 8'b0010_0000) begin n_fail++; $display("FAIL wide_direct_y: got %b exp 00100000", b1.y); end
    b1.mode = 1; b1.dwell = 4'd1;
    tick();
    n_tests++; if (b1.y !== 8'b0000_0001) begin n_fail++; $display("FAIL wide_scan_entry_y: got %b exp 00000001", b1.y); end
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (b1.wrap === 1'b1) begin
        nwrap++;
        if (first < 0) first = t;
      end
    end
    n_tests++; if (nwrap != 2) begin n_fail++; $display("FAIL wide_wrap_count: got %0d exp 2", nwrap); end
    n_tests++; if (first != 16) begin n_fail++; $display("FAIL wide_wrap_period: got %0d exp 16", first); end
  endtask

  task automatic test_random();
    logic [7:0] e0, e1;
    logic pw0 = 1'b0, pw1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      b0.en    = ($urandom_range(0, 7) != 0);
      b0.mode  = ($urandom_range(0, 3) != 0);
      b0.sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b0.dwell = 4'($urandom_range(0, 4));
      b1.en    = ($urandom_range(0, 7) != 0);
      b1.mode  = ($urandom_range(0, 3) != 0);
      b1.sel   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) b1.dwell = 4'($urandom_range(0, 15));
      tick();
      e0 = my(0, 4, 1'b1);
      e1 = my(1, 8, 1'b0);
      n_tests++; if ({4'b0, b0.y} !== e0 || b0.cur_idx !== 2'(mpos[0]) || b0.wrap !== mwrap[0]) begin
        n_fail++; $display("FAIL rand0 i=%0d: got y=%b idx=%0d wrap=%b exp y=%b idx=%0d wrap=%b",
                           i, b0.y, b0.cur_idx, b0.wrap, e0[3:0], mpos[0], mwrap[0]);
      end
      n_tests++; if (b1.y !== e1 || b1.cur_idx !== 3'(mpos[1]) || b1.wrap !== mwrap[1]) begin
        n_fail++; $display("FAIL rand1 i=%0d: got y=%b idx=%0d wrap=%b exp y=%b idx=%0d wrap=%b",
                           i, b1.y, b1.cur_idx, b1.wrap, e1, mpos[1], mwrap[1]);
      end
      n_tests++; if ($countones(~b0.y) != int'(mon[0]) || $countones(b1.y) != int'(mon[1])) begin
        n_fail++; $display("FAIL rand_onehot i=%0d: got y0=%b y1=%b exp active %0d/%0d", i, b0.y, b1.y, mon[0], mon[1]);
      end
      n_tests++; if ((pw0 && b0.wrap) || (pw1 && b1.wrap)) begin
        n_fail++; $display("FAIL rand_wrap_double i=%0d: got wrap0=%b wrap1=%b exp no repeat", i, b0.wrap, b1.wrap);
      end
      pw0 = b0.wrap;
      pw1 = b1.wrap;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell0();
    test_dwell_change();
    test_rst_midscan();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
